// File: rtl/mux_2_arbiter.sv
// mux_2_arbiter: two-input round-robin arbiter with a one-entry registered output stage; `MUX_ARB_LAST_EN adds last flags and a packet-lock FSM
module mux_2_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
`ifdef MUX_ARB_LAST_EN
  input  logic             a_last,
  input  logic             b_last,
  output logic             out_last,
`endif
  input  logic             out_ready
);
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             sel_q, sel_d;
  logic             last_grant_q, last_grant_d;
  logic             load_en, a_ok, b_ok, gnt_b, acc;
`ifdef MUX_ARB_LAST_EN
  typedef enum logic [1:0] {OPEN, LOCK_A, LOCK_B} state_t;
  state_t state_q, state_d;
  logic   out_last_q, out_last_d, g_last;
`endif
  always_comb begin
    load_en      = rst_n && (!out_valid_q || out_ready);
`ifdef MUX_ARB_LAST_EN
    a_ok         = a_valid && state_q != LOCK_B;
    b_ok         = b_valid && state_q != LOCK_A;
`else
    a_ok         = a_valid;
    b_ok         = b_valid;
`endif
    gnt_b        = b_ok && (!a_ok || !last_grant_q);
    acc          = load_en && (a_ok || b_ok);
    a_ready      = load_en && a_ok && !gnt_b;
    b_ready      = load_en && gnt_b;
    out_valid_d  = acc || (out_valid_q && !out_ready);
    out_data_d   = acc ? (gnt_b ? b_data : a_data) : out_data_q;
    sel_d        = acc ? gnt_b : sel_q;
    last_grant_d = acc ? gnt_b : last_grant_q;
`ifdef MUX_ARB_LAST_EN
    g_last       = gnt_b ? b_last : a_last;
    out_last_d   = acc ? g_last : out_last_q;
    state_d      = !acc ? state_q : g_last ? OPEN : gnt_b ? LOCK_B : LOCK_A;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
`ifdef MUX_ARB_LAST_EN
      out_last_q   <= 1'b0;
      state_q      <= OPEN;
`endif
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
`ifdef MUX_ARB_LAST_EN
      out_last_q   <= out_last_d;
      state_q      <= state_d;
`endif
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel       = sel_q;
`ifdef MUX_ARB_LAST_EN
  assign out_last  = out_last_q;
`endif
endmodule

// File: tb/tb_mux_2_arbiter.sv
// tb_mux_2_arbiter: table-driven directed bench for mux_2_arbiter
module tb_mux_2_arbiter;
  logic       clk, rst_n, a_valid, b_valid, out_ready;
  logic [7:0] a_data, b_data, out_data;
  logic       a_ready, b_ready, sel, out_valid;
`ifdef MUX_ARB_LAST_EN
  logic       a_last, b_last, out_last;
`endif
  int tests = 0, fails = 0;
  typedef struct {
    logic av; logic [7:0] ad; logic al;
    logic bv; logic [7:0] bd; logic bl;
    logic ordy;
    logic ear; logic ebr; logic eov; logic [7:0] eod; logic esel; logic eol;
  } vec_t;
  vec_t tbl[14];
  vec_t lck[4];
  mux_2_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data),
`ifdef MUX_ARB_LAST_EN
    .a_last(a_last), .b_last(b_last), .out_last(out_last),
`endif
    .out_ready(out_ready)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic apply(input vec_t v, input string tag);
    a_valid = v.av; a_data = v.ad; b_valid = v.bv; b_data = v.bd; out_ready = v.ordy;
`ifdef MUX_ARB_LAST_EN
    a_last = v.al; b_last = v.bl;
`endif
    #1;
    chk({tag, " a_ready"}, a_ready, v.ear);
    chk({tag, " b_ready"}, b_ready, v.ebr);
    @(posedge clk); #1;
    chk({tag, " out_valid"}, out_valid, v.eov);
    chk({tag, " out_data"}, out_data, v.eod);
    chk({tag, " sel"}, sel, v.esel);
`ifdef MUX_ARB_LAST_EN
    chk({tag, " out_last"}, out_last, v.eol);
`endif
  endtask
  initial begin
    //          av ad    al bv bd    bl ordy ear ebr eov eod   esel eol
    tbl[0]  = '{1, 8'hA0, 1, 1, 8'hB0, 1, 1,  1,  0,  1, 8'hA0, 0, 1};
    tbl[1]  = '{1, 8'hA1, 1, 1, 8'hB0, 1, 1,  0,  1,  1, 8'hB0, 1, 1};
    tbl[2]  = '{1, 8'hA1, 1, 1, 8'hB1, 1, 1,  1,  0,  1, 8'hA1, 0, 1};
    tbl[3]  = '{1, 8'hA2, 1, 1, 8'hB1, 1, 1,  0,  1,  1, 8'hB1, 1, 1};
    tbl[4]  = '{1, 8'h11, 1, 0, 8'h00, 1, 1,  1,  0,  1, 8'h11, 0, 1};
    tbl[5]  = '{0, 8'h00, 1, 0, 8'h00, 1, 1,  0,  0,  0, 8'h11, 0, 1};
    tbl[6]  = '{0, 8'h00, 1, 1, 8'h5C, 1, 0,  0,  1,  1, 8'h5C, 1, 1};
    tbl[7]  = '{1, 8'hA5, 1, 1, 8'hB6, 1, 0,  0,  0,  1, 8'h5C, 1, 1};
    tbl[8]  = '{1, 8'hA5, 1, 1, 8'hB6, 1, 0,  0,  0,  1, 8'h5C, 1, 1};
    tbl[9]  = '{1, 8'hA5, 1, 1, 8'hB6, 1, 0,  0,  0,  1, 8'h5C, 1, 1};
    tbl[10] = '{1, 8'hA5, 1, 1, 8'hB6, 1, 1,  1,  0,  1, 8'hA5, 0, 1};
    tbl[11] = '{0, 8'h00, 1, 1, 8'hB6, 1, 1,  0,  1,  1, 8'hB6, 1, 1};
    tbl[12] = '{0, 8'h00, 1, 0, 8'h00, 1, 0,  0,  0,  1, 8'hB6, 1, 1};
    tbl[13] = '{0, 8'h00, 1, 0, 8'h00, 1, 1,  0,  0,  0, 8'hB6, 1, 1};
    lck[0]  = '{1, 8'hC0, 0, 1, 8'hD0, 1, 1,  1,  0,  1, 8'hC0, 0, 0};
    lck[1]  = '{1, 8'hC1, 0, 1, 8'hD0, 1, 1,  1,  0,  1, 8'hC1, 0, 0};
    lck[2]  = '{1, 8'hC2, 1, 1, 8'hD0, 1, 1,  1,  0,  1, 8'hC2, 0, 1};
    lck[3]  = '{1, 8'hC3, 1, 1, 8'hD0, 1, 1,  0,  1,  1, 8'hD0, 1, 1};
    rst_n = 0; a_valid = 1; a_data = 8'hEE; b_valid = 1; b_data = 8'hDD; out_ready = 1;
`ifdef MUX_ARB_LAST_EN
    a_last = 1; b_last = 1;
`endif
    #12;
    chk("rst out_valid", out_valid, 0);
    chk("rst sel", sel, 0);
    chk("rst out_data", out_data, 0);
    chk("rst a_ready", a_ready, 0);
    chk("rst b_ready", b_ready, 0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("v%0d", i));
    a_valid = 1; a_data = 8'h77; b_valid = 0; out_ready = 0;
    @(posedge clk); #1;
    chk("mid pre out_valid", out_valid, 1);
    chk("mid pre out_data", out_data, 8'h77);
    #2 rst_n = 0;
    #1;
    chk("mid async out_valid", out_valid, 0);
    chk("mid async out_data", out_data, 0);
    a_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    chk("mid after out_valid", out_valid, 0);
    chk("mid after out_data", out_data, 0);
`ifdef MUX_ARB_LAST_EN
    for (int i = 0; i < 4; i++) apply(lck[i], $sformatf("lock%0d", i));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mux_2_arbiter.md
# mux_2_arbiter

- Two-input round-robin arbiter with a one-entry registered output stage.
- Sits directly upstream of `mux_2` and drives its `select` input.
- Each accepted beat is latched together with the `sel` that identifies its source, so `sel` stays stable while the downstream stage consumes the beat.
- Valid/ready handshakes on both inputs and on the output; full throughput of one beat per cycle.

## Interface
- `WIDTH`, 8, data width of each input and the output.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `a_valid`  in  1  source A (mux `in_a`) beat present.
- `a_data`  in  WIDTH  source A payload.
- `a_ready`  out  1  source A beat accepted this cycle.
- `b_valid`  in  1  source B (mux `in_b`) beat present.
- `b_data`  in  WIDTH  source B payload.
- `b_ready`  out  1  source B beat accepted this cycle.
- `sel`  out  1  registered source of the held beat: 0 = A, 1 = B. Feeds `mux_2.select`.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  WIDTH  held payload.
- `out_ready`  in  1  downstream accepts the held beat.
- `a_last`, `b_last`  in  1, `out_last`  out  1: present only with `MUX_ARB_LAST_EN`.

## Operation
- `load_en = !out_valid || out_ready`.
  - The output register loads only when `load_en` is set.
  - Combinational path `out_ready -> a_ready/b_ready` is intended.
- Arbitration is combinational when `load_en` is set:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the source that is not `last_grant`.
- Ready outputs:
  - Exactly the granted source sees ready = 1; the other sees 0.
  - Neither is ready if `load_en` = 0 or no input is valid.
- On an accepted beat (valid && ready):
  - `out_data <= granted data`
  - `sel <= granted id`
  - `out_valid <= 1`
  - `last_grant <= granted id`
- If `out_ready` = 1 and no input is accepted, `out_valid <= 0`. `out_data` and `sel` hold their last values.
- `last_grant` changes only on an accepted beat.
- Simultaneous output drain and input load: the new beat replaces the old one in the same edge, with no bubble.
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `sel` = 0, `out_last` = 0.
  - `last_grant` = 1, so A wins the first tie.
  - Lock state = OPEN.
- Reset asserted mid-operation clears the held beat; it is dropped, not replayed.

## Timing
- Latency: input accept at edge N gives `out_valid` = 1 with the data during cycle N+1.
- Throughput: 1 beat/cycle while `out_ready` is held at 1.
- Under continuous contention, grants alternate A, B, A, B …
- `sel`, `out_valid`, `out_data` and `out_last` are register outputs, glitch-free for `mux_2`.
- A held beat (`out_valid` && !`out_ready`) keeps `out_data`, `sel` and `out_last` stable until it is accepted.

## Configuration
- Macro: `MUX_ARB_LAST_EN`.
- Defined: adds `a_last`, `b_last` and `out_last`, plus a packet-lock FSM with states OPEN, LOCK_A and LOCK_B.
  - OPEN: round-robin as above.
  - Accepting a beat with last = 0 from X moves the FSM to LOCK_X.
  - In LOCK_X only X can be granted; the other source's ready = 0 even when its valid = 1.
  - Accepting a beat with last = 1 from X returns the FSM to OPEN and updates `last_grant` to X.
  - `out_last` is registered with the data.
- Undefined: the ports and the FSM are absent. Every beat is arbitrated independently; behaviour is identical to OPEN permanently.

## Test plan
- Reset with `rst_n` = 0 while inputs are valid.
  - Required: `out_valid` = 0, `sel` = 0, `out_data` = 0, both readies = 0.
  - After release: the first tie grants A.
- A only: `a_data` = 0x11, `out_ready` = 1.
  - Required: `a_ready` = 1; the next cycle shows `out_valid` = 1, `out_data` = 0x11, `sel` = 0.
- Both valid for 4 cycles: `a_data` = 0xA0..0xA3, `b_data` = 0xB0..0xB3, `out_ready` = 1.
  - Required: output 0xA0, 0xB0, 0xA1, 0xB1 with `sel` 0, 1, 0, 1 and no bubbles.
- Backpressure: hold `out_ready` = 0 for 3 cycles with a beat 0x5C from B held.
  - Required: `out_data` = 0x5C and `sel` = 1 stable; `a_ready` = `b_ready` = 0.
  - Raising `out_ready` loads the next beat in the same edge.
- Reset mid-stream: assert `rst_n` while `out_valid` = 1.
  - Required: `out_valid` drops immediately (asynchronously) and the beat never appears.
- With `MUX_ARB_LAST_EN` defined: A sends 3 beats (last = 0, 0, 1) while B is continuously valid.
  - Required: `b_ready` = 0 until A's last beat is accepted; the next grant is B; `out_last` = 1 only on A's third beat.
